// File: rtl/assoc_cache_if.sv
// Request/response handshake used on both sides of the cache: the requester
// holds read_request/write_request until the one-cycle response pulse.
interface assoc_cache_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  read_request;
  logic                  write_request;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  response;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output read_request, write_request, addr, write_data,
    input  response, read_data
  );

  modport slave (
    input  read_request, write_request, addr, write_data,
    output response, read_data
  );
endinterface

// File: rtl/assoc_cache.sv
// N-way set-associative cache, one word per line, round-robin replacement,
// write-back/write-allocate or write-through/no-allocate, saturating hit/miss counters.
module assoc_cache #(
  parameter int CACHE_SIZE    = 32,
  parameter int WAYS          = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int WRITE_BACK    = 1,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  assoc_cache_if.slave             up,
  assoc_cache_if.master            mem,
  output logic [COUNTER_WIDTH-1:0] hit_count,
  output logic [COUNTER_WIDTH-1:0] miss_count
);
  localparam int SETS       = CACHE_SIZE / WAYS;
  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS;
  localparam int WAY_BITS   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam bit WB         = (WRITE_BACK != 0);

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, FILL, MEMWRITE, RESPOND} state_t;
  state_t state, next_state;

  logic [TAG_BITS-1:0]   tag_mem    [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_mem   [SETS][WAYS];
  logic [WAYS-1:0]       valid      [SETS];
  logic [WAYS-1:0]       dirty      [SETS];
  logic [WAY_BITS-1:0]   victim_ptr [SETS];

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_write;
  logic [WAY_BITS-1:0]   victim_way;
  logic [DATA_WIDTH-1:0] read_data_q;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  assign index = req_addr[INDEX_BITS-1:0];
  assign tag   = req_addr[ADDR_WIDTH-1:INDEX_BITS];

  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic [WAY_BITS-1:0] victim_sel;
  logic                victim_dirty;
  logic [WAY_BITS-1:0] next_ptr;

  // Descending scan so the lowest-numbered invalid way overrides the pointer.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_sel = victim_ptr[index];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[index][WAY_BITS'(w)] && (tag_mem[index][WAY_BITS'(w)] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid[index][WAY_BITS'(w)]) victim_sel = WAY_BITS'(w);
    end
  end

  assign victim_dirty = WB && valid[index][victim_sel] && dirty[index][victim_sel];
  assign next_ptr     = (victim_ptr[index] == WAY_BITS'(WAYS - 1)) ? '0
                                                                   : victim_ptr[index] + WAY_BITS'(1);

  logic                  install;
  logic                  install_dirty;
  logic [WAY_BITS-1:0]   install_way;
  logic [DATA_WIDTH-1:0] install_data;
  logic                  hit_write;

  always_comb begin
    install       = 1'b0;
    install_dirty = 1'b0;
    install_way   = victim_way;
    install_data  = req_data;
    hit_write     = 1'b0;
    case (state)
      COMPARE: begin
        if (hit) begin
          hit_write = req_write;
        end else if (req_write && WB && !victim_dirty) begin
          install       = 1'b1;
          install_dirty = 1'b1;
          install_way   = victim_sel;
        end
      end
      WRITEBACK: begin
        if (mem.response && req_write) begin
          install       = 1'b1;
          install_dirty = 1'b1;
        end
      end
      FILL: begin
        if (mem.response) begin
          install      = 1'b1;
          install_data = mem.read_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (install) begin
      tag_mem[index][install_way]  <= tag;
      data_mem[index][install_way] <= install_data;
    end else if (hit_write) begin
      data_mem[index][hit_way] <= req_data;
    end
  end

  // The install update sits after the case so an allocating write-back keeps its new dirty bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s]      <= '0;
        dirty[s]      <= '0;
        victim_ptr[s] <= '0;
      end
      req_addr    <= '0;
      req_data    <= '0;
      req_write   <= 1'b0;
      victim_way  <= '0;
      read_data_q <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (up.read_request || up.write_request) begin
            req_addr  <= up.addr;
            req_data  <= up.write_data;
            req_write <= up.write_request;
          end
        end
        COMPARE: begin
          victim_way <= victim_sel;
          if (hit) begin
            if (hit_count != '1) hit_count <= hit_count + COUNTER_WIDTH'(1);
            if (req_write) begin
              if (WB) dirty[index][hit_way] <= 1'b1;
            end else begin
              read_data_q <= data_mem[index][hit_way];
            end
          end else if (miss_count != '1) begin
            miss_count <= miss_count + COUNTER_WIDTH'(1);
          end
        end
        WRITEBACK: if (mem.response) dirty[index][victim_way] <= 1'b0;
        FILL:      if (mem.response) read_data_q <= mem.read_data;
        default: ;
      endcase
      if (install) begin
        valid[index][install_way] <= 1'b1;
        dirty[index][install_way] <= install_dirty;
        victim_ptr[index]         <= next_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (up.read_request || up.write_request) next_state = COMPARE;
      COMPARE: begin
        if (req_write && !WB)  next_state = MEMWRITE;
        else if (hit)          next_state = RESPOND;
        else if (victim_dirty) next_state = WRITEBACK;
        else if (req_write)    next_state = RESPOND;
        else                   next_state = FILL;
      end
      WRITEBACK: if (mem.response) next_state = req_write ? RESPOND : FILL;
      FILL:      if (mem.response) next_state = RESPOND;
      MEMWRITE:  if (mem.response) next_state = RESPOND;
      RESPOND:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  logic                  resp_o;
  logic                  mem_rd_o;
  logic                  mem_wr_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;

  always_comb begin
    resp_o      = 1'b0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      WRITEBACK: begin
        mem_wr_o    = 1'b1;
        mem_addr_o  = {tag_mem[index][victim_way], index};
        mem_wdata_o = data_mem[index][victim_way];
      end
      FILL: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = req_addr;
      end
      MEMWRITE: begin
        mem_wr_o    = 1'b1;
        mem_addr_o  = req_addr;
        mem_wdata_o = req_data;
      end
      RESPOND: resp_o = 1'b1;
      default: ;
    endcase
  end

  assign up.response       = resp_o;
  assign up.read_data      = read_data_q;
  assign mem.read_request  = mem_rd_o;
  assign mem.write_request = mem_wr_o;
  assign mem.addr          = mem_addr_o;
  assign mem.write_data    = mem_wdata_o;
endmodule
